// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and default frame/baud constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11} uart_state_t;
  localparam int UART_DBIT = 8;
  localparam int UART_SB_TICK = 16;
  localparam int UART_DIVISOR_9600 = 651;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: modulo-DIVISOR counter giving a one-cycle tick (ports clk, reset, clr sync clear, tick)
module baud_tick_gen #(
  parameter int DIVISOR = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIVISOR - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: start/DBIT data (LSB first)/stop UART transmitter (in tx_start, din; out tx, tx_busy, tx_done_tick)
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DBIT = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int DIVISOR = UART_DIVISOR_9600
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);
  localparam int TW = $clog2(SB_TICK) + 1;
  localparam int BW = DBIT > 1 ? $clog2(DBIT) : 1;
  uart_state_t state_q, state_d;
  logic [TW-1:0] s_q, s_d;
  logic [BW-1:0] n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic tick, clr, tx_d;
  baud_tick_gen #(.DIVISOR(DIVISOR)) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    n_d = n_q;
    b_d = b_q;
    clr = 1'b0;
    tx_done_tick = 1'b0;
    unique case (state_q)
      IDLE:
        if (tx_start) begin
          state_d = START;
          b_d = din;
          s_d = '0;
          clr = 1'b1;
        end
      START:
        if (tick) begin
          if (s_q == TW'(15)) begin
            state_d = DATA;
            s_d = '0;
            n_d = '0;
          end else s_d = s_q + 1'b1;
        end
      DATA:
        if (tick) begin
          if (s_q == TW'(15)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == BW'(DBIT - 1)) state_d = STOP;
            else n_d = n_q + 1'b1;
          end else s_d = s_q + 1'b1;
        end
      STOP:
        if (tick) begin
          if (s_q == TW'(SB_TICK - 1)) begin
            state_d = IDLE;
            tx_done_tick = 1'b1;
          end else s_d = s_q + 1'b1;
        end
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? b_d[0] : 1'b1;
  end
  // tx and tx_busy are registered from the next state so they switch on the acceptance edge itself
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      s_q <= '0;
      n_q <= '0;
      b_q <= '0;
      tx <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      n_q <= n_d;
      b_q <= b_d;
      tx <= tx_d;
      tx_busy <= state_d != IDLE;
    end
endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-wide UART transmitter for the Basys3 UART link. It accepts one byte per `tx_start` request and shifts it out on the serial line. The frame is one start bit, DBIT data bits sent LSB first, and one stop bit. Bit timing comes from an internal 16x-oversampling baud tick. It sits between the debounced-button / control logic (which raises `tx_start`) and the FPGA `RsTx` pin.

## Interface
- `DBIT`, 8: data bits per frame (5–9 supported).
- `SB_TICK`, 16: baud ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `DIVISOR`, 651: clk cycles per baud tick (100 MHz / (9600 × 16) ≈ 651).
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high.
- `tx_start` in 1: level request to transmit; sampled only in IDLE.
- `din` in DBIT: byte to send; captured on the accepting edge.
- `tx` out 1: serial line, idle high, registered.
- `tx_busy` out 1: high from the acceptance edge until the frame ends.
- `tx_done_tick` out 1: one-cycle pulse at end of the stop bit.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **Reset values:** state = IDLE, `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0, tick counter = 0, bit counter = 0, shift register = 0, baud counter = 0.
- **IDLE:**
  - `tx` = 1.
  - On `tx_start` = 1: `din` → shift register, clear the tick counter and baud counter, go to START.
- **START:**
  - `tx` = 0.
  - On each baud tick, tick counter +1.
  - When the tick counter is 15 and a tick occurs: clear it, clear the bit counter, go to DATA.
- **DATA:**
  - `tx` = shift register [0].
  - After 16 ticks: shift right by 1, bit counter +1, tick counter = 0.
  - When the bit counter is DBIT−1 and 16 ticks elapse: go to STOP.
- **STOP:**
  - `tx` = 1.
  - After SB_TICK ticks: assert `tx_done_tick` for that cycle, go to IDLE.
- `tx_busy` = (state ≠ IDLE), registered together with the state.
- **Baud generator:**
  - Modulo-DIVISOR counter; tick = 1 for one cycle when the count equals DIVISOR−1.
  - Synchronously cleared on frame acceptance, so the start bit is exactly 16 × DIVISOR cycles.
- **Widths:**
  - Baud counter: $clog2(DIVISOR).
  - Tick counter: $clog2(SB_TICK) + 1 bits, wide enough for the stop count.
  - Bit counter: $clog2(DBIT).
  - All counters wrap only through the explicit clears above; there is no free overflow.

## Timing
- Acceptance: `tx_start` is sampled high at edge k in IDLE. At edge k, `tx` falls to 0 and `tx_busy` rises to 1.
- Start bit: 16 × DIVISOR cycles. Each data bit: 16 × DIVISOR cycles. Stop bit: SB_TICK × DIVISOR cycles.
- Frame length, edge k to the `tx_done_tick` edge: (16 × (1 + DBIT) + SB_TICK) × DIVISOR cycles.
- `tx_done_tick` is high during the last stop cycle. At the following edge, `tx_busy` = 0.
- `tx_start` while busy: ignored and not queued. `din` changes while busy have no effect.
- `tx_start` in the same cycle as `tx_done_tick`: ignored. If still high on the next cycle (IDLE), it is accepted there.
- Back-to-back throughput: a `tx_start` held high continuously gives frames with one idle-high cycle between them.
- Reset mid-frame: `tx` returns to 1 immediately and asynchronously, the FSM goes to IDLE, and no `tx_done_tick` is produced.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding: IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11.
  - Default constants `UART_DBIT` = 8, `UART_SB_TICK` = 16, `UART_DIVISOR_9600` = 651.
  - The future receiver reuses this package.
- One sub-module, `baud_tick_gen`, with parameter DIVISOR and ports clk, reset, clr, tick. The receiver will instantiate it too.
- Top level: FSM, counters and shift register.

## Test plan
All scenarios use DIVISOR = 4, so one bit = 64 cycles.
- Reset: hold `reset` 3 cycles → `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0 during and after.
- Single frame: `din` = 8'hA5, `tx_start` 1-cycle pulse → `tx` sequence 0,1,0,1,0,0,1,0,1,1 at 64-cycle spacing; `tx_done_tick` exactly 640 cycles after acceptance; `tx_busy` high for 640 cycles.
- Ignored request: start 8'h3C, then pulse `tx_start` with `din` = 8'hFF at cycle 200 → line still carries 8'h3C; only one `tx_done_tick`.
- Back-to-back: `tx_start` held high, `din` = 8'h00 then 8'hFF → two complete frames with exactly one idle-high cycle between them.
- Mid-frame reset: assert `reset` at cycle 300 of a frame → `tx` = 1 in the same cycle, no `tx_done_tick`; a new `tx_start` after release sends a clean full frame.
- Stop length: SB_TICK = 32, `din` = 8'h55 → stop bit 128 cycles; `tx_done_tick` at cycle 704.
